// File: rtl/fir_feed_pkg.sv
// Shared types and constants for the FIR sample feeder.
package fir_feed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int         RD_LATENCY_MAX = 2;
  localparam logic [1:0] BE_ALL         = 2'b11;

endpackage

// File: rtl/fir_feed_pacer.sv
// Sample-period pacer: ticks when the down-counter reaches zero, then reloads the divider.
module fir_feed_pacer #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == '0);

  // Loading zero makes the first tick land on the very next enabled cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= i_div;
    end else if (i_en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Streams a block of samples from on-chip memory port s2 into the FIR Compiler II sink,
// one read per pacer tick, with optional looping and a completion pulse.
module fir_sample_feeder
  import fir_feed_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1,
  parameter int DIV_W      = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_loop,
  output logic              status_busy,
  output logic              status_done,
  output logic [ADDR_W-1:0] status_count,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [1:0]        mem_byteenable,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] fir_data,
  output logic              fir_valid,
  output logic [1:0]        fir_error
);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
      $error("fir_sample_feeder: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  state_e r_state;
  state_e w_state_next;

  logic [ADDR_W-1:0]     r_base;
  logic [ADDR_W-1:0]     r_len;
  logic [ADDR_W-1:0]     r_index;
  logic [DIV_W-1:0]      r_div;
  logic                  r_loop;
  logic [RD_LATENCY-1:0] r_inflight;
  logic [DATA_W-1:0]     r_fir_data;
  logic                  r_fir_valid;
  logic [ADDR_W-1:0]     r_count;
  logic                  r_done;

  logic w_tick;
  logic w_issue;
  logic w_last;
  logic w_start_ok;
  logic w_exit;

  assign w_start_ok = (r_state == IDLE) && cfg_start && (cfg_len != '0);
  assign w_issue    = (r_state == RUN) && w_tick && !cfg_stop;
  assign w_last     = (r_index == r_len - 1'b1);
  assign w_exit     = r_inflight[RD_LATENCY-1];

  fir_feed_pacer #(
    .DIV_W(DIV_W)
  ) u_pacer (
    .i_clk  (clk_clk),
    .i_rst_n(reset_reset_n),
    .i_load (w_start_ok),
    .i_en   (r_state == RUN),
    .i_div  (r_div),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_next = RUN;
      RUN: begin
        if (cfg_stop) begin
          w_state_next = DRAIN;
        end else if (w_issue && w_last && !r_loop) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN:   if (r_inflight == '0) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    status_busy    = (r_state != IDLE);
    mem_chipselect = w_issue;
    mem_address    = w_issue ? (r_base + r_index) : '0;
  end

  assign status_done    = r_done;
  assign status_count   = r_count;
  assign fir_data       = r_fir_data;
  assign fir_valid      = r_fir_valid;
  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_writedata  = '0;
  assign mem_byteenable = BE_ALL;
  assign fir_error      = 2'b00;

  // In-flight tracker: one bit per outstanding read, marching toward the readdata slot.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_inflight[0] <= 1'b0;
    end else begin
      r_inflight[0] <= w_issue;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < RD_LATENCY; gi++) begin : g_track
      always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
          r_inflight[gi] <= 1'b0;
        end else begin
          r_inflight[gi] <= r_inflight[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_base      <= '0;
      r_len       <= '0;
      r_index     <= '0;
      r_div       <= '0;
      r_loop      <= 1'b0;
      r_fir_data  <= '0;
      r_fir_valid <= 1'b0;
      r_count     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_fir_valid <= w_exit;
      if (r_state == IDLE && cfg_start) begin
        if (cfg_len == '0) begin
          r_done <= 1'b1;
        end else begin
          r_base  <= cfg_base;
          r_len   <= cfg_len;
          r_div   <= cfg_div;
          r_loop  <= cfg_loop;
          r_index <= '0;
          r_count <= '0;
        end
      end
      if (w_issue) begin
        r_index <= w_last ? '0 : r_index + 1'b1;
      end
      if (w_exit) begin
        r_fir_data <= mem_readdata;
        r_count    <= r_count + 1'b1;
      end
      if (r_state == DRAIN && r_inflight == '0) begin
        r_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: RD_LATENCY=1 and RD_LATENCY=2 instances share one stimulus
// stream; a per-cycle schedule model is compared against both every cycle.
module tb_fir_sample_feeder;

  localparam int N = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n, cfg_start, cfg_stop, cfg_loop;
  logic [15:0] cfg_base, cfg_len, cfg_div;

  logic [1:0]       o_busy, o_done, o_cs, o_clken, o_write, o_valid;
  logic [1:0][15:0] o_count, o_addr, o_wdata, o_data, rdata;
  logic [1:0][1:0]  o_be, o_err;

  logic [15:0] mem [0:65535];

  bit          e_cs   [0:N-1];
  logic [15:0] e_addr [0:N-1];
  bit          e_val  [0:1][0:N-1];
  logic [15:0] e_data [0:1][0:N-1];
  bit          e_done [0:1][0:N-1];
  bit          e_busy [0:1][0:N-1];
  logic [15:0] e_cnt  [0:1][0:N-1];

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;
  int last_done = 0;
  int t_s;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      logic [15:0] rq0, rq1;
      fir_sample_feeder #(
        .ADDR_W(16), .DATA_W(16), .RD_LATENCY(gi + 1), .DIV_W(16)
      ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .cfg_base      (cfg_base),
        .cfg_len       (cfg_len),
        .cfg_div       (cfg_div),
        .cfg_loop      (cfg_loop),
        .status_busy   (o_busy[gi]),
        .status_done   (o_done[gi]),
        .status_count  (o_count[gi]),
        .mem_address   (o_addr[gi]),
        .mem_chipselect(o_cs[gi]),
        .mem_clken     (o_clken[gi]),
        .mem_write     (o_write[gi]),
        .mem_writedata (o_wdata[gi]),
        .mem_byteenable(o_be[gi]),
        .mem_readdata  (rdata[gi]),
        .fir_data      (o_data[gi]),
        .fir_valid     (o_valid[gi]),
        .fir_error     (o_err[gi])
      );
      // s2 model: word appears gi+1 cycles after the read; junk when no read was issued.
      always @(posedge clk) begin
        rq0 <= o_cs[gi] ? mem[o_addr[gi]] : 16'hDEAD;
        rq1 <= rq0;
      end
      if (gi == 0) begin : g_l1
        assign rdata[gi] = rq0;
      end else begin : g_l2
        assign rdata[gi] = rq1;
      end
    end
  endgenerate

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s inst=%0d cycle=%0d got=%0h expected=%0h", nm, k, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  // Schedule of a run: reads every div+1 cycles from S+1, data L+1 cycles later,
  // done one cycle after the tracker empties once issuing has ended.
  task automatic plan(input int s, input logic [15:0] base, input logic [15:0] len,
                      input int div, input bit loop, input int stopc);
    for (int k = 0; k < 2; k++) begin
      int lat, t, n, idx, tlast, drain, empty, dn, beats;
      lat = k + 1; t = s + 1; n = 0; idx = 0; tlast = 0;
      if (len == 16'd0) begin
        e_done[k][s+1] = 1'b1;
        if (s + 2 > last_done) last_done = s + 2;
      end else begin
        while (t < stopc && (loop || n < int'(len))) begin
          logic [15:0] a;
          a = base + 16'(idx);
          e_cs[t] = 1'b1;
          e_addr[t] = a;
          e_val[k][t+lat+1] = 1'b1;
          e_data[k][t+lat+1] = mem[a];
          tlast = t;
          n++;
          idx = (idx + 1 == int'(len)) ? 0 : idx + 1;
          t += div + 1;
        end
        drain = (!loop && n == int'(len)) ? tlast + 1 : stopc + 1;
        empty = (n > 0 && tlast + lat + 1 > drain) ? tlast + lat + 1 : drain;
        dn = empty + 1;
        e_done[k][dn] = 1'b1;
        for (int c = s + 1; c < dn; c++) e_busy[k][c] = 1'b1;
        beats = 0;
        for (int c = s + 1; c < N; c++) begin
          if (e_val[k][c]) beats++;
          e_cnt[k][c] = 16'(beats);
        end
        if (dn > last_done) last_done = dn;
      end
    end
  endtask

  task automatic clear_after(input int r);
    for (int c = r + 1; c < N; c++) begin
      e_cs[c] = 1'b0; e_addr[c] = 16'h0;
      for (int k = 0; k < 2; k++) begin
        e_val[k][c] = 1'b0; e_data[k][c] = 16'h0; e_done[k][c] = 1'b0;
        e_busy[k][c] = 1'b0; e_cnt[k][c] = 16'h0;
      end
    end
  endtask

  task automatic start_run(input logic [15:0] base, input logic [15:0] len, input logic [15:0] div,
                           input bit loop, input int stop_off);
    t_s = cyc;
    cfg_base = base; cfg_len = len; cfg_div = div; cfg_loop = loop; cfg_start = 1'b1;
    plan(t_s, base, len, int'(div), loop, (stop_off > 0) ? t_s + stop_off : N - 16);
    step();
    cfg_start = 1'b0; cfg_base = 16'hBEEF; cfg_len = 16'h0007; cfg_div = 16'h0005; cfg_loop = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < N) begin
      for (int k = 0; k < 2; k++) begin
        chk("chipselect", k, 32'(o_cs[k]), 32'(e_cs[cyc]));
        if (e_cs[cyc]) chk("address", k, 32'(o_addr[k]), 32'(e_addr[cyc]));
        chk("fir_valid", k, 32'(o_valid[k]), 32'(e_val[k][cyc]));
        if (e_val[k][cyc]) chk("fir_data", k, 32'(o_data[k]), 32'(e_data[k][cyc]));
        chk("done", k, 32'(o_done[k]), 32'(e_done[k][cyc]));
        chk("busy", k, 32'(o_busy[k]), 32'(e_busy[k][cyc]));
        chk("count", k, 32'(o_count[k]), 32'(e_cnt[k][cyc]));
        chk("constants", k, 32'({o_write[k], o_wdata[k], o_be[k], o_clken[k], o_err[k]}),
            32'({1'b0, 16'h0000, 2'b11, 1'b1, 2'b00}));
      end
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5C3;
    mem[16'h0100] = 16'h1111; mem[16'h0101] = 16'h2222;
    mem[16'h0102] = 16'h3333; mem[16'h0103] = 16'h4444;
    clear_after(-1);
    rst_n = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_loop = 1'b0;
    cfg_base = 16'h0; cfg_len = 16'h0; cfg_div = 16'h0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      chk("reset_busy", k, 32'(o_busy[k]), 32'd0);
      chk("reset_count", k, 32'(o_count[k]), 32'd0);
      chk("reset_valid_data", k, 32'({o_valid[k], o_data[k]}), 32'd0);
    end
    chk_en = 1'b1;
    step();

    // Back-to-back block of four samples.
    start_run(16'h0100, 16'd4, 16'd0, 1'b0, 0);
    wait_to(t_s + 1);
    chk("t1_first_addr", 0, 32'({o_cs[0], o_addr[0]}), 32'h1_0100);
    wait_to(t_s + 3);
    chk("t1_first_beat", 0, 32'({o_valid[0], o_data[0]}), 32'h1_1111);
    wait_to(t_s + 6);
    chk("t1_last_beat", 0, 32'(o_data[0]), 32'h4444);
    wait_to(t_s + 7);
    chk("t1_done_l1", 0, 32'({o_done[0], o_busy[0]}), 32'b10);
    wait_to(t_s + 8);
    chk("t1_done_l2", 1, 32'(o_done[1]), 32'd1);
    chk("t1_count", 0, 32'(o_count[0]), 32'd4);
    wait_to(last_done + 2);

    // Paced run; a second start mid-run must be ignored.
    start_run(16'h0100, 16'd3, 16'd3, 1'b0, 0);
    wait_to(t_s + 5);
    chk("t2_second_addr", 0, 32'({o_cs[0], o_addr[0]}), 32'h1_0101);
    cfg_start = 1'b1; cfg_base = 16'h0200; cfg_len = 16'd8; cfg_div = 16'd0; cfg_loop = 1'b0;
    step();
    cfg_start = 1'b0;
    wait_to(t_s + 11);
    chk("t2_third_beat", 0, 32'({o_valid[0], o_data[0]}), 32'h1_3333);
    wait_to(t_s + 12);
    chk("t2_done", 0, 32'(o_done[0]), 32'd1);
    wait_to(last_done + 2);
    chk("t2_count", 1, 32'(o_count[1]), 32'd3);

    // Address wrap past 0xFFFF.
    start_run(16'hFFFE, 16'd4, 16'd0, 1'b0, 0);
    wait_to(t_s + 2);
    chk("t3_addr_ffff", 0, 32'(o_addr[0]), 32'hFFFF);
    wait_to(t_s + 3);
    chk("t3_addr_0000", 1, 32'({o_cs[1], o_addr[1]}), 32'h1_0000);
    wait_to(t_s + 4);
    chk("t3_addr_0001", 0, 32'(o_addr[0]), 32'h0001);
    wait_to(last_done + 2);

    // Looping two-sample block, stopped after five issues.
    start_run(16'h0100, 16'd2, 16'd0, 1'b1, 6);
    wait_to(t_s + 4);
    chk("t4_addr_pass2", 0, 32'(o_addr[0]), 32'h0101);
    wait_to(t_s + 5);
    chk("t4_addr_pass3", 1, 32'(o_addr[1]), 32'h0100);
    wait_to(t_s + 6);
    cfg_stop = 1'b1;
    wait_to(t_s + 8);
    chk("t4_done_l1", 0, 32'(o_done[0]), 32'd1);
    wait_to(t_s + 9);
    chk("t4_done_l2", 1, 32'(o_done[1]), 32'd1);
    chk("t4_count_l1", 0, 32'(o_count[0]), 32'd5);
    chk("t4_count_l2", 1, 32'(o_count[1]), 32'd5);
    wait_to(last_done + 2);
    cfg_stop = 1'b0;
    step();

    // Zero-length start: done next cycle, no read.
    start_run(16'h0100, 16'd0, 16'd0, 1'b0, 0);
    chk("t5_done", 0, 32'({o_done[0], o_cs[0], o_busy[0]}), 32'b100);
    wait_to(last_done + 2);

    // Reset two cycles after the first issue.
    start_run(16'h0100, 16'd4, 16'd0, 1'b0, 0);
    wait_to(t_s + 3);
    rst_n = 1'b0;
    clear_after(t_s + 3);
    step();
    for (int k = 0; k < 2; k++) begin
      chk("t6_reset_outs", k, 32'({o_busy[k], o_done[k], o_cs[k], o_valid[k], o_addr[k]}), 32'd0);
      chk("t6_reset_data", k, 32'({o_count[k], o_data[k]}), 32'd0);
    end
    step();
    rst_n = 1'b1;
    wait_to(t_s + 14);

    // Normal run after reset.
    start_run(16'h0102, 16'd2, 16'd2, 1'b0, 0);
    wait_to(last_done + 2);
    chk("t7_count", 0, 32'(o_count[0]), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_sample_feeder.md
# fir_sample_feeder

Sequencer that streams a block of 16-bit samples from the on-chip memory's second port (s2) into the FIR Compiler II Avalon-ST sink. The HPS fills the buffer through s1. Fabric logic or HPS-driven PIO then programs base, length and sample period and issues a start. The feeder paces reads, forwards each read word to the FIR sink as one valid beat, and reports completion. It sits in the fabric top level between the `soc_system` instance's `onchip_memory2_0_s2_*` and `fir_compiler_ii_0_avalon_streaming_sink_*` conduits.

## Interface
Parameters:
- `ADDR_W`, 16: s2 word address width; also the width of length and count.
- `DATA_W`, 16: sample width.
- `RD_LATENCY`, 1: s2 read latency in cycles. Legal values are 1 or 2.
- `DIV_W`, 16: sample-period divider width.

Ports:
- `clk_clk`  in  1: the single clock. Reset is synchronous and active-low.
- `reset_reset_n`  in  1: synchronous, active-low reset.
- `cfg_start`  in  1: one-cycle start pulse. Accepted only in IDLE.
- `cfg_stop`  in  1: level. Ends a run after the current issue.
- `cfg_base`  in  ADDR_W: first word address. Latched on start.
- `cfg_len`  in  ADDR_W: samples per pass. Latched on start.
- `cfg_div`  in  DIV_W: sample period minus 1, in clocks. Latched on start.
- `cfg_loop`  in  1: repeat the block until stopped. Latched on start.
- `status_busy`  out  1: high from the cycle after an accepted start until done.
- `status_done`  out  1: one-cycle completion pulse.
- `status_count`  out  ADDR_W: fir_valid beats since the last start. Wraps modulo 2^ADDR_W.
- `mem_address`  out  ADDR_W: to the s2 port.
- `mem_chipselect`  out  1: to the s2 port.
- `mem_clken`  out  1: to the s2 port.
- `mem_write`  out  1: to the s2 port.
- `mem_writedata`  out  DATA_W: to the s2 port.
- `mem_byteenable`  out  2: to the s2 port.
- `mem_readdata`  in  DATA_W: from the s2 port.
- `fir_data`  out  DATA_W: to the FIR sink.
- `fir_valid`  out  1: to the FIR sink.
- `fir_error`  out  2: to the FIR sink.

## Operation
- Constant outputs: `mem_write`=0, `mem_writedata`=0, `mem_byteenable`=2'b11, `mem_clken`=1, `fir_error`=2'b00.
- States:
  - IDLE
    - `cfg_start` with `cfg_len`≠0: latch the config, clear `index` and `status_count`, load the pacer so the first tick is immediate, go to RUN.
    - `cfg_start` with `cfg_len`=0: `status_done` pulses the next cycle; state stays IDLE; no read is issued.
  - RUN: issue a read on each pacer tick.
    - `mem_chipselect`=1 and `mem_address`=base+index, modulo 2^ADDR_W (wraps past 0xFFFF).
    - After the issue with index=len−1: if loop is set and `cfg_stop`=0, index returns to 0 and the run continues. Otherwise go to DRAIN.
    - `cfg_stop`=1 in any RUN cycle: no issue that cycle, even if a tick coincides; go to DRAIN.
  - DRAIN: no issues. When the in-flight tracker is empty, pulse `status_done`, drop `status_busy`, go to IDLE.
- `cfg_start` while busy is ignored. Config inputs are don't-care outside the start cycle.
- In-flight tracker: a RD_LATENCY-deep valid shift register. When a bit exits, `mem_readdata` is registered into `fir_data`, `fir_valid` is pulsed and `status_count` is incremented.
- The FIR sink has no ready signal. Every valid beat is accepted, so there is no backpressure.
- Reset while `reset_reset_n`=0: all state is cleared on the next edge. In-flight reads are discarded, with no `fir_valid` and no `status_done`.

## Timing
- Reset values:
  - `status_busy`, `status_done`, `status_count`, `mem_address`, `mem_chipselect`, `fir_data`, `fir_valid` are 0.
  - The constant outputs hold their stated values.
- First read: `mem_chipselect` goes high in cycle S+1, where start is sampled at S.
- Issue cadence: one read every cfg_div+1 cycles. A value of 0 means back-to-back reads.
- Latency: a read issued in cycle T produces `fir_valid` in cycle T+RD_LATENCY+1, one cycle wide, with `fir_data` stable in that cycle.
- `status_done`: one cycle after the last `fir_valid`.
- `status_busy`: rises at S+1 and falls in the same cycle `status_done` is high.

## Structure
- Package `fir_feed_pkg`:
  - state enum {IDLE, RUN, DRAIN};
  - `RD_LATENCY_MAX`=2;
  - constant `BE_ALL`=2'b11.
- Sub-module `fir_feed_pacer`: a DIV_W down-counter with `load`, `div` and `tick` signals. `tick` fires when the count is 0, and the counter then reloads `div`.
- Elaboration-time assertion: 1 ≤ RD_LATENCY ≤ 2.

## Test plan
- Memory 0x0100..0x0103 = 1111/2222/3333/4444; base=0x0100, len=4, div=0, RD_LATENCY=1 → chipselect high 4 consecutive cycles starting S+1; fir_valid 4 consecutive cycles starting S+3 with data 1111..4444; done at S+7; count=4.
- len=3, div=3 → chipselect pulses 4 cycles apart; fir_valid pulses 4 cycles apart; done one cycle after the third beat.
- base=0xFFFE, len=4 → addresses FFFE, FFFF, 0000, 0001.
- loop=1, len=2, div=0; stop raised after 5 issues → addresses alternate base and base+1; exactly 5 fir_valid beats; a single done pulse; count=5. Repeat with RD_LATENCY=2: fir_valid shifts one cycle later.
- len=0 → done at S+1; chipselect never asserted. A second start during a run is ignored: addresses and count are unchanged.
- Reset asserted two cycles after the first issue → every output at its reset value on the next edge; no fir_valid or done afterwards.
